// File: rtl/layer_sequencer.sv
// Layer sequencer: runs enc1 -> enc2 -> lambda -> enc3 -> enc4 one layer at a time and strobes the capture registers.
// Optional feature: define SEQ_TIMEOUT_EN to enable the enc1 done watchdog and the ERR state.
//
// state  | meaning
// IDLE   | waiting for start
// ENC1   | first layer running until enc1_done
// ENC2   | z_mean/z_var layers running for ENC2_CYCLES
// LAMBDA | sampling layer running for LAMBDA_CYCLES
// ENC3   | hidden classifier running for ENC3_CYCLES
// ENC4   | classifier output running for ENC4_CYCLES
// DONE   | one-cycle completion pulse
// ERR    | enc1 watchdog expired; held until abort or reset
module layer_sequencer #(
    parameter int ENC2_CYCLES    = 40,
    parameter int LAMBDA_CYCLES  = 12,
    parameter int ENC3_CYCLES    = 8,
    parameter int ENC4_CYCLES    = 40,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       enc1_done,
    output logic       enc1_start,
    output logic       enc2_start,
    output logic       lambda_start,
    output logic       enc3_start,
    output logic       enc4_start,
    output logic       cap1_en,
    output logic       cap3_en,
    output logic       busy,
    output logic       done_flag,
    output logic       error,
    output logic [2:0] stage
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENC1   = 3'd1;
    localparam logic [2:0] S_ENC2   = 3'd2;
    localparam logic [2:0] S_LAMBDA = 3'd3;
    localparam logic [2:0] S_ENC3   = 3'd4;
    localparam logic [2:0] S_ENC4   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [15:0] ENC2_LD   = 16'(ENC2_CYCLES);
    localparam logic [15:0] LAMBDA_LD = 16'(LAMBDA_CYCLES);
    localparam logic [15:0] ENC3_LD   = 16'(ENC3_CYCLES);
    localparam logic [15:0] ENC4_LD   = 16'(ENC4_CYCLES);
    localparam logic [15:0] TO_LD     = 16'(TIMEOUT_CYCLES);

    logic [2:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        cnt_last;

    assign cnt_last = (cnt == 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic error_q;

    // Sticky until reset; abort out of ERR deliberately leaves it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            error_q <= 1'b0;
        else if (state_nxt == S_ERR)
            error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_ENC1;
                        cnt_nxt   = TO_LD;
                    end
                end
                S_ENC1: begin
                    if (enc1_done) begin
                        state_nxt = S_ENC2;
                        cnt_nxt   = ENC2_LD;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (cnt_last) begin
                        state_nxt = S_ERR;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
`endif
                end
                S_ENC2: begin
                    if (cnt_last) begin
                        state_nxt = S_LAMBDA;
                        cnt_nxt   = LAMBDA_LD;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_LAMBDA: begin
                    if (cnt_last) begin
                        state_nxt = S_ENC3;
                        cnt_nxt   = ENC3_LD;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_ENC3: begin
                    if (cnt_last) begin
                        state_nxt = S_ENC4;
                        cnt_nxt   = ENC4_LD;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_ENC4: begin
                    if (cnt_last) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_DONE: state_nxt = S_IDLE;
                S_ERR: begin
`ifdef SEQ_TIMEOUT_EN
                    state_nxt = S_ERR;
`else
                    state_nxt = S_IDLE;
`endif
                end
            endcase
        end
    end

    // Strobes are gated by abort so an aborted cycle never captures or completes.
    always_comb begin
        enc1_start   = 1'b1;
        enc2_start   = 1'b1;
        lambda_start = 1'b1;
        enc3_start   = 1'b1;
        enc4_start   = 1'b1;
        cap1_en      = 1'b0;
        cap3_en      = 1'b0;
        busy         = 1'b0;
        done_flag    = 1'b0;
        stage        = state;
        case (state)
            S_ENC1: begin
                enc1_start = 1'b0;
                busy       = 1'b1;
                cap1_en    = enc1_done & ~abort;
            end
            S_ENC2: begin
                enc2_start = 1'b0;
                busy       = 1'b1;
            end
            S_LAMBDA: begin
                lambda_start = 1'b0;
                busy         = 1'b1;
            end
            S_ENC3: begin
                enc3_start = 1'b0;
                busy       = 1'b1;
                cap3_en    = cnt_last & ~abort;
            end
            S_ENC4: begin
                enc4_start = 1'b0;
                busy       = 1'b1;
            end
            S_DONE: done_flag = ~abort;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: a default-parameter instance and an all-ones/short-timeout instance,
// each checked every cycle against an expected stage schedule built from the layer window lengths.
module tb_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, abort0, done0;
    logic        start1, abort1, done1;
    logic [12:0] o0, o1;

    int checks = 0;
    int errors = 0;
    bit err_exp [2];

    layer_sequencer u_def (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .enc1_done(done0),
        .enc1_start(o0[12]), .enc2_start(o0[11]), .lambda_start(o0[10]),
        .enc3_start(o0[9]), .enc4_start(o0[8]), .cap1_en(o0[7]), .cap3_en(o0[6]),
        .busy(o0[5]), .done_flag(o0[4]), .error(o0[3]), .stage(o0[2:0])
    );

    layer_sequencer #(
        .ENC2_CYCLES(1), .LAMBDA_CYCLES(1), .ENC3_CYCLES(1), .ENC4_CYCLES(1), .TIMEOUT_CYCLES(16)
    ) u_fast (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .enc1_done(done1),
        .enc1_start(o1[12]), .enc2_start(o1[11]), .lambda_start(o1[10]),
        .enc3_start(o1[9]), .enc4_start(o1[8]), .cap1_en(o1[7]), .cap3_en(o1[6]),
        .busy(o1[5]), .done_flag(o1[4]), .error(o1[3]), .stage(o1[2:0])
    );

    // Expected output word for a given stage, derived from the output rules of each state.
    function automatic logic [12:0] mk(int st, bit c1, bit c3, bit er, bit ab);
        logic [2:0] s3;
        s3 = 3'(st);
        return {st != 1, st != 2, st != 3, st != 4, st != 5, c1, c3,
                (st >= 1 && st <= 5), (st == 6) && !ab, er, s3};
    endfunction

    function automatic logic [12:0] obs(int d);
        return (d == 0) ? o0 : o1;
    endfunction

    task automatic chk(string tag, logic [12:0] got, logic [12:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic drive(int d, bit s, bit a, bit e);
        if (d == 0) begin
            start0 = s; abort0 = a; done0 = e;
        end else begin
            start1 = s; abort1 = a; done1 = e;
        end
    endtask

    task automatic cyc(int d, bit s, bit a, bit e, logic [12:0] want, string tag);
        @(negedge clk);
        drive(d, s, a, e);
        #1;
        chk(tag, obs(d), want);
    endtask

    // One inference on instance d: enc1_done rises in ENC1 cycle k; optional abort/reset at schedule index.
    task automatic run(int d, int k, bit hold, int abort_at, int rst_at);
        int n [4];
        int sched [$];
        int last1, last3, st;
        bit ab, e;
        if (d == 0) n = '{40, 12, 8, 40};
        else        n = '{1, 1, 1, 1};
        sched = {};
        repeat (k) sched.push_back(1);
        for (int j = 0; j < 4; j++) repeat (n[j]) sched.push_back(j + 2);
        sched.push_back(6);
        last1 = k - 1;
        last3 = k + n[0] + n[1] + n[2] - 1;
        cyc(d, 1'b1, 1'b0, k == 1, mk(0, 0, 0, err_exp[d], 0), "idle_start");
        for (int i = 0; i < sched.size(); i++) begin
            ab = (i == abort_at);
            e  = (i >= k - 1);
            st = sched[i];
            cyc(d, hold, ab, e, mk(st, (i == last1) && !ab, (i == last3) && !ab, err_exp[d], ab), "run");
            if (ab) break;
            if (i == rst_at) begin
                #1 reset = 1'b0;
                #1;
                err_exp[0] = 1'b0;
                err_exp[1] = 1'b0;
                chk("rst_async", obs(d), mk(0, 0, 0, 0, 0));
                chk("rst_async_other", obs(1 - d), mk(0, 0, 0, 0, 0));
                @(negedge clk);
                drive(d, 1'b1, 1'b0, 1'b0);
                #1;
                chk("rst_held", obs(d), mk(0, 0, 0, 0, 0));
                drive(d, 1'b0, 1'b0, 1'b0);
                reset = 1'b1;
                break;
            end
        end
        cyc(d, hold, 1'b0, 1'b0, mk(0, 0, 0, err_exp[d], 0), "post_idle");
        if (hold) begin
            cyc(d, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, err_exp[d], 1), "restart_enc1");
            cyc(d, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, err_exp[d], 0), "abort_idle");
        end
    endtask

    initial begin
        int k;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        #3;
        chk("reset_def", o0, mk(0, 0, 0, 0, 0));
        chk("reset_fast", o1, mk(0, 0, 0, 0, 0));
        drive(0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ignores_start", o0, mk(0, 0, 0, 0, 0));
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "idle_after_reset");

        run(0, 20, 1'b0, -1, -1);
        run(0, 5, 1'b1, -1, -1);
        run(0, 7, 1'b0, 7 + 40 + 4, -1);

        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 30);
            repeat ($urandom_range(0, 3)) cyc(0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, err_exp[0], 0), "gap");
            run(0, k, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, k + 100)) : -1, -1);
        end

        run(1, 1, 1'b0, -1, -1);
        run(1, 1, 1'b1, -1, -1);
        run(1, 3, 1'b0, -1, -1);

`ifdef SEQ_TIMEOUT_EN
        cyc(1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "to_start");
        for (int i = 0; i < 16; i++) cyc(1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0), "to_enc1");
        err_exp[1] = 1'b1;
        repeat (3) cyc(1, 1'b1, 1'b0, 1'b0, mk(7, 0, 0, 1, 0), "to_err");
        cyc(1, 1'b0, 1'b1, 1'b0, mk(7, 0, 0, 1, 1), "to_abort");
        cyc(1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1, 0), "to_idle_sticky");
`else
        cyc(1, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "wait_start");
        for (int i = 0; i < 40; i++) cyc(1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0), "wait_enc1");
        cyc(1, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1), "wait_abort");
        cyc(1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0), "wait_idle");
`endif
        run(1, 1, 1'b0, -1, -1);

        run(0, 3, 1'b0, -1, 3 + 40 + 12 + 3);
        run(0, 2, 1'b0, -1, -1);
        run(1, 2, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
